// File: rtl/sample_memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module : sample_memory_responder_if
// Brief  : Bus bundle between the transform engine's control FSM and the
//          sample memory responder. It carries the streaming load port, the
//          Clear request, and the read request/response signals.
//          master : control/load side (drives requests and samples)
//          slave  : memory responder (drives ready/status/read data)
// Rev    : 1.0  initial release
// ============================================================================
interface sample_memory_responder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  Clear;
  logic                  Wr_Valid;
  logic [DATA_WIDTH-1:0] Wr_Data;
  logic                  Wr_Ready;
  logic                  Loaded;
  logic                  Read_Enable;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] Data_Out;
  logic                  Data_Valid;
  logic                  Read_Error;
  logic [ADDR_WIDTH:0]   Read_Count;

  modport master (
    output Clear, Wr_Valid, Wr_Data, Read_Enable, Address,
    input  Wr_Ready, Loaded, Data_Out, Data_Valid, Read_Error, Read_Count
  );

  modport slave (
    input  Clear, Wr_Valid, Wr_Data, Read_Enable, Address,
    output Wr_Ready, Loaded, Data_Out, Data_Valid, Read_Error, Read_Count
  );
endinterface
`default_nettype wire

// File: rtl/sample_memory_responder.sv
`default_nettype none
// ============================================================================
// Module : sample_memory_responder
// Brief  : 64-entry sample buffer for the 8x8 transform engine. A streaming
//          load port fills it in raster order ({u,v} addressing); once every
//          entry has been written, read requests are answered with one
//          registered word exactly one cycle later.
// Ports  : Clock - rising-edge clock
//          Reset - asynchronous, active-high
//          bus   - slave side of sample_memory_responder_if
//                  (Clear, load port, read request and response, status)
// Rev    : 1.0  initial release
// ============================================================================
module sample_memory_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                        Clock,
  input  logic                        Reset,
  sample_memory_responder_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_COUNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {
    LOADING = 1'b0,
    SERVING = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  read_error_q, read_error_d;
  logic [ADDR_WIDTH:0]   read_count_q, read_count_d;
  logic                  wr_fire;
  logic                  loaded;

  // Sample storage; intentionally not reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign loaded = (state_q == SERVING);

  // A write handshake coinciding with Clear is dropped.
  assign wr_fire = bus.Wr_Valid && (state_q == LOADING) && !bus.Clear;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    read_error_d = 1'b0;
    read_count_d = read_count_q;

    case (state_q)
      LOADING: begin
        if (wr_fire) begin
          // Pointer wraps to 0 naturally on the final write.
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (&wr_ptr_q) begin
            state_d = SERVING;
          end
        end
      end
      SERVING: begin
        state_d = SERVING;
      end
      default: begin
        state_d = LOADING;
      end
    endcase

    // Reads look at the status before this edge, so a read issued with the
    // final load write is still rejected.
    if (bus.Read_Enable) begin
      if (loaded) begin
        data_out_d   = mem_q[bus.Address];
        data_valid_d = 1'b1;
        if (read_count_q != C_COUNT_MAX) begin
          read_count_d = read_count_q + 1'b1;
        end
      end else begin
        data_out_d   = '0;
        read_error_d = 1'b1;
      end
    end

    // Clear restarts loading but does not cancel a read serviced this cycle.
    if (bus.Clear) begin
      state_d      = LOADING;
      wr_ptr_d     = '0;
      read_count_d = '0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= LOADING;
      wr_ptr_q     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      read_error_q <= 1'b0;
      read_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      read_error_q <= read_error_d;
      read_count_q <= read_count_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= bus.Wr_Data;
    end
  end

  assign bus.Wr_Ready   = (state_q == LOADING);
  assign bus.Loaded     = loaded;
  assign bus.Data_Out   = data_out_q;
  assign bus.Data_Valid = data_valid_q;
  assign bus.Read_Error = read_error_q;
  assign bus.Read_Count = read_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_memory_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_sample_memory_responder
// Brief  : Self-checking bench for sample_memory_responder. A transaction-
//          level model (sample count, read count, array of samples) predicts
//          every output each cycle; directed scenarios plus a randomized
//          phase drive the DUT, with literal spot checks at key points.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sample_memory_responder;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic Clock;
  logic Reset;

  sample_memory_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sample_memory_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  int            m_nw;     // samples accepted since last reset/clear
  int            m_reads;  // reads serviced since last reset/clear
  logic [DW-1:0] e_dout;
  logic          e_dv;
  logic          e_err;

  task automatic model_reset();
    m_nw    = 0;
    m_reads = 0;
    e_dout  = '0;
    e_dv    = 1'b0;
    e_err   = 1'b0;
  endtask

  always @(posedge Reset) model_reset();

  always @(posedge Clock) begin
    bit pre_loaded;
    if (Reset) begin
      model_reset();
    end else begin
      pre_loaded = (m_nw == DEPTH);
      if (bus.Read_Enable) begin
        if (pre_loaded) begin
          e_dout  = m_mem[bus.Address];
          e_dv    = 1'b1;
          e_err   = 1'b0;
          m_reads = m_reads + 1;
        end else begin
          e_dout = '0;
          e_dv   = 1'b0;
          e_err  = 1'b1;
        end
      end else begin
        e_dv  = 1'b0;
        e_err = 1'b0;
      end
      if (bus.Clear) begin
        m_nw    = 0;
        m_reads = 0;
      end else if (bus.Wr_Valid && !pre_loaded) begin
        m_mem[m_nw] = bus.Wr_Data;
        m_nw        = m_nw + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clock) begin
    check("wr_ready",   32'(bus.Wr_Ready),   32'(m_nw < DEPTH));
    check("loaded",     32'(bus.Loaded),     32'(m_nw == DEPTH));
    check("data_valid", 32'(bus.Data_Valid), 32'(e_dv));
    check("read_error", 32'(bus.Read_Error), 32'(e_err));
    check("data_out",   32'(bus.Data_Out),   32'(e_dout));
    check("read_count", 32'(bus.Read_Count), 32'((m_reads > DEPTH) ? DEPTH : m_reads));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge Clock);
  endtask

  task automatic idle_inputs();
    bus.Clear       = 1'b0;
    bus.Wr_Valid    = 1'b0;
    bus.Wr_Data     = '0;
    bus.Read_Enable = 1'b0;
    bus.Address     = '0;
  endtask

  task automatic read_one(input int addr);
    bus.Read_Enable = 1'b1;
    bus.Address     = AW'(addr);
    cyc();
    bus.Read_Enable = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    model_reset();
    idle_inputs();
    cyc();
    check("reset_data_out", 32'(bus.Data_Out), 32'h0);
    check("reset_count",    32'(bus.Read_Count), 32'h0);
    cyc();
    Reset = 1'b0;

    // 1: continuous load of value = index
    for (int i = 0; i < DEPTH; i++) begin
      bus.Wr_Valid = 1'b1;
      bus.Wr_Data  = DW'(i);
      if (i == DEPTH - 1) check("not_loaded_before_last", 32'(bus.Loaded), 32'h0);
      cyc();
    end
    check("t1_loaded",   32'(bus.Loaded),   32'h1);
    check("t1_wr_ready", 32'(bus.Wr_Ready), 32'h0);
    bus.Wr_Data = 8'hFF;   // ignored while serving
    cyc();
    bus.Wr_Valid = 1'b0;

    // 2: single read of address 19
    read_one(19);
    check("t2_valid", 32'(bus.Data_Valid), 32'h1);
    check("t2_data",  32'(bus.Data_Out),   32'd19);
    check("t2_count", 32'(bus.Read_Count), 32'd1);

    // 3: back-to-back reads 0..63
    for (int a = 0; a < DEPTH; a++) begin
      bus.Read_Enable = 1'b1;
      bus.Address     = AW'(a);
      cyc();
      check("t3_data", 32'(bus.Data_Out), 32'(a));
    end
    bus.Read_Enable = 1'b0;
    check("t3_count_sat", 32'(bus.Read_Count), 32'd64);
    cyc();

    // 5a: Clear while serving, with a write in the same cycle
    bus.Clear    = 1'b1;
    bus.Wr_Valid = 1'b1;
    bus.Wr_Data  = 8'hEE;
    cyc();
    bus.Clear    = 1'b0;
    bus.Wr_Valid = 1'b0;
    check("t5_loaded0", 32'(bus.Loaded),     32'h0);
    check("t5_count0",  32'(bus.Read_Count), 32'h0);

    // reload value = 63-index, pausing at wr_ptr=10 for an early read
    for (int i = 0; i < 10; i++) begin
      bus.Wr_Valid = 1'b1;
      bus.Wr_Data  = DW'(63 - i);
      cyc();
    end
    bus.Wr_Valid = 1'b0;

    // 4: read before loaded
    read_one(3);
    check("t4_error", 32'(bus.Read_Error), 32'h1);
    check("t4_valid", 32'(bus.Data_Valid), 32'h0);
    check("t4_data",  32'(bus.Data_Out),   32'h0);
    cyc();
    check("t4_error_pulse", 32'(bus.Read_Error), 32'h0);

    // finish reload; final write coincides with a read -> error
    for (int i = 10; i < DEPTH; i++) begin
      bus.Wr_Valid    = 1'b1;
      bus.Wr_Data     = DW'(63 - i);
      bus.Read_Enable = (i == DEPTH - 1);
      cyc();
    end
    bus.Wr_Valid    = 1'b0;
    bus.Read_Enable = 1'b0;
    check("final_write_read_err", 32'(bus.Read_Error), 32'h1);
    check("t5_reloaded",          32'(bus.Loaded),     32'h1);
    read_one(0);
    check("t5_data0", 32'(bus.Data_Out), 32'd63);

    // 6: asynchronous reset mid-load
    bus.Clear = 1'b1;
    cyc();
    bus.Clear = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.Wr_Valid = 1'b1;
      bus.Wr_Data  = DW'(i);
      cyc();
    end
    bus.Wr_Valid = 1'b0;
    #2 Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.Wr_Valid = 1'b1;
      bus.Wr_Data  = 8'hA5;
      if (i == DEPTH - 1) check("t6_not_loaded_63", 32'(bus.Loaded), 32'h0);
      cyc();
    end
    bus.Wr_Valid = 1'b0;
    check("t6_loaded_64", 32'(bus.Loaded), 32'h1);
    read_one(5);
    check("t6_data5", 32'(bus.Data_Out), 32'hA5);

    // randomized phase, including Clear/read collisions
    for (int n = 0; n < 600; n++) begin
      bus.Clear       = ($urandom_range(0, 150) == 0);
      bus.Wr_Valid    = $urandom_range(0, 3) != 0;
      bus.Wr_Data     = DW'($urandom);
      bus.Read_Enable = $urandom_range(0, 1) == 1;
      bus.Address     = AW'($urandom);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
